// File: rtl/score_display.sv
// N-digit BCD score line for the dino game: score/high-score counters,
// frame-synchronous display capture with blink, and a 2-stage glyph pipeline.
module score_display #(
  parameter int unsigned DIGITS    = 4,
  parameter logic [9:0]  X0        = 10'd400,
  parameter logic [9:0]  Y0        = 10'd5,
  parameter int unsigned CELL_LOG2 = 3,
  parameter bit          SATURATE  = 1'b1,
  parameter bit          BLANK_LZ  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clear,
  input  logic                game_over,
  input  logic                frame,
  input  logic                show_hi,
  input  logic [9:0]          pix_x,
  input  logic [9:0]          pix_y,
  output logic                pixel,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] hi_score,
  output logic                new_hi
);
  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned COLS = 6 * DIGITS;

  logic [W-1:0] score_inc;
  logic [W-1:0] disp;
  logic         all_nines;
  logic         beats_hi;
  logic [4:0]   frame_cnt;
  logic         blank;

  // Rows packed r5..r0, bit n of a row = glyph column n (column 0 on the left).
  function automatic logic [3:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
    logic [31:0] g;
    case (d)
      4'd0:    g = {8'h00, 4'hF, 4'h9, 4'h9, 4'h9, 4'h9, 4'hF};
      4'd1:    g = {8'h00, 4'h7, 4'h2, 4'h2, 4'h2, 4'h3, 4'h2};
      4'd2:    g = {8'h00, 4'hF, 4'h1, 4'h1, 4'hF, 4'h8, 4'hF};
      4'd3:    g = {8'h00, 4'hF, 4'h8, 4'h8, 4'hF, 4'h8, 4'hF};
      4'd4:    g = {8'h00, 4'h8, 4'h8, 4'hF, 4'hA, 4'hC, 4'h8};
      4'd5:    g = {8'h00, 4'hF, 4'h8, 4'h8, 4'hF, 4'h1, 4'hF};
      4'd6:    g = {8'h00, 4'hF, 4'h9, 4'h9, 4'hF, 4'h1, 4'hF};
      4'd7:    g = {8'h00, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'hF};
      4'd8:    g = {8'h00, 4'hF, 4'h9, 4'h9, 4'hF, 4'h9, 4'hF};
      4'd9:    g = {8'h00, 4'hF, 4'h8, 4'h8, 4'hF, 4'h9, 4'hF};
      default: g = '0;
    endcase
    return g[4*r +: 4];
  endfunction

  always_comb begin
    logic carry;
    score_inc = score;
    carry     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign all_nines = (score == {DIGITS{4'h9}});
  assign beats_hi  = game_over && (score > hi_score);

  always_ff @(posedge clk) begin
    if (reset) begin
      score     <= '0;
      hi_score  <= '0;
      new_hi    <= 1'b0;
      disp      <= '0;
      blank     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (clear)
        score <= '0;
      else if (inc && !(all_nines && SATURATE))
        score <= score_inc;
      if (beats_hi)
        hi_score <= score;
      if (clear)
        new_hi <= 1'b0;
      else if (beats_hi)
        new_hi <= 1'b1;
      if (frame) begin
        disp      <= show_hi ? hi_score : score;
        blank     <= new_hi && !show_hi && frame_cnt[4];
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

  // Stage 1: cell geometry; off-screen coordinates wrap large and fall outside.
  logic [9:0] rx, ry, cx, cy;
  logic       in_region_c;
  logic [2:0] s1_slot, s1_col, s1_row;
  logic       s1_valid;

  assign rx          = pix_x - X0;
  assign ry          = pix_y - Y0;
  assign cx          = rx >> CELL_LOG2;
  assign cy          = ry >> CELL_LOG2;
  assign in_region_c = (cx < 10'(COLS)) && (cy < 10'd6);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_slot  <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      s1_valid <= in_region_c;
      s1_slot  <= 3'(cx / 10'd6);
      s1_col   <= 3'(cx % 10'd6);
      s1_row   <= cy[2:0];
    end
  end

  // Stage 2: digit select, leading-zero suppression and ROM lookup on disp.
  logic [DIGITS-1:0] lz;
  logic [3:0]        nib;
  logic              show_digit;
  logic [3:0]        row_bits;
  logic              pixel_c;

  always_comb begin
    logic hz;
    lz = '0;
    hz = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      hz    = hz && (disp[4*i +: 4] == 4'd0);
      lz[i] = hz && BLANK_LZ;
    end
    nib        = 4'hF;
    show_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (s1_slot == 3'(DIGITS - 1 - i)) begin
        nib        = disp[4*i +: 4];
        show_digit = !lz[i];
      end
    end
    row_bits = glyph_row(nib, s1_row);
    pixel_c  = s1_valid && !blank && show_digit && (s1_col < 3'd4) && row_bits[s1_col[1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset)
      pixel <= 1'b0;
    else
      pixel <= pixel_c;
  end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: decimal-arithmetic reference model of a saturating and a
// wrapping instance, checked every cycle, plus directed literal expectations.
module tb_score_display;
  localparam int DIGITS = 4;
  localparam int X0     = 400;
  localparam int Y0     = 5;
  localparam int CELL   = 8;
  localparam int MAXV   = 9999;

  logic       clk = 1'b0;
  logic       reset = 1'b1, inc = 1'b0, clear = 1'b0, game_over = 1'b0;
  logic       frame = 1'b0, show_hi = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic       pixel_a, pixel_b, new_hi_a, new_hi_b;
  logic [15:0] score_a, score_b, hi_a, hi_b;

  int n_vec = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  score_display #(.DIGITS(DIGITS), .X0(10'd400), .Y0(10'd5), .CELL_LOG2(3),
                  .SATURATE(1'b1), .BLANK_LZ(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .inc(inc), .clear(clear), .game_over(game_over),
    .frame(frame), .show_hi(show_hi), .pix_x(pix_x), .pix_y(pix_y),
    .pixel(pixel_a), .score(score_a), .hi_score(hi_a), .new_hi(new_hi_a));

  score_display #(.DIGITS(DIGITS), .X0(10'd400), .Y0(10'd5), .CELL_LOG2(3),
                  .SATURATE(1'b0), .BLANK_LZ(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .inc(inc), .clear(clear), .game_over(game_over),
    .frame(frame), .show_hi(show_hi), .pix_x(pix_x), .pix_y(pix_y),
    .pixel(pixel_b), .score(score_b), .hi_score(hi_b), .new_hi(new_hi_b));

  // ---------------- reference model (decimal integers, character-art glyphs)
  int m_score [2], m_hi [2], m_disp [2];
  bit m_new [2], m_blank [2], m_pixel [2], m_got [2];
  int m_fcnt;
  bit m_s1v;
  int m_s1x, m_s1y;

  function automatic int pow10(int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] bcd(int v);
    logic [31:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic bit glyph_on(int d, int r, int c);
    string s;
    case (d)
      0: s = {"XXXX", "X..X", "X..X", "X..X", "X..X", "XXXX"};
      1: s = {".X..", "XX..", ".X..", ".X..", ".X..", "XXX."};
      2: s = {"XXXX", "...X", "XXXX", "X...", "X...", "XXXX"};
      3: s = {"XXXX", "...X", "XXXX", "...X", "...X", "XXXX"};
      4: s = {"...X", "..XX", ".X.X", "XXXX", "...X", "...X"};
      5: s = {"XXXX", "X...", "XXXX", "...X", "...X", "XXXX"};
      6: s = {"XXXX", "X...", "XXXX", "X..X", "X..X", "XXXX"};
      7: s = {"XXXX", "...X", "...X", "...X", "...X", "...X"};
      8: s = {"XXXX", "X..X", "XXXX", "X..X", "X..X", "XXXX"};
      default: s = {"XXXX", "X..X", "XXXX", "...X", "...X", "XXXX"};
    endcase
    return s.getc(r * 4 + c) == "X";
  endfunction

  function automatic bit model_pix(int x, int y, int val, bit blk);
    int rx, ry, cx, cy, slot, col, idx;
    rx = (x - X0) & 1023;
    ry = (y - Y0) & 1023;
    cx = rx / CELL;
    cy = ry / CELL;
    if (blk || cx >= 6 * DIGITS || cy >= 6) return 1'b0;
    slot = cx / 6;
    col  = cx % 6;
    if (col > 3) return 1'b0;
    idx = DIGITS - 1 - slot;
    if (idx > 0 && val < pow10(idx)) return 1'b0;
    return glyph_on((val / pow10(idx)) % 10, cy, col);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_score[k] = 0; m_hi[k] = 0; m_new[k] = 0;
        m_disp[k] = 0; m_blank[k] = 0; m_pixel[k] = 0;
      end
      m_fcnt = 0;
      m_s1v  = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_pixel[k] = m_s1v && model_pix(m_s1x, m_s1y, m_disp[k], m_blank[k]);
        if (frame) begin
          m_disp[k]  = show_hi ? m_hi[k] : m_score[k];
          m_blank[k] = m_new[k] && !show_hi && (m_fcnt >= 16);
        end
        m_got[k] = game_over && (m_score[k] > m_hi[k]);
        if (m_got[k]) m_hi[k] = m_score[k];
        if (clear) begin
          m_score[k] = 0;
          m_new[k]   = 0;
        end else begin
          if (m_got[k]) m_new[k] = 1;
          if (inc) begin
            if (m_score[k] < MAXV) m_score[k] = m_score[k] + 1;
            else if (k == 1)       m_score[k] = 0;
          end
        end
      end
      if (frame) m_fcnt = (m_fcnt + 1) % 32;
      m_s1v = 1;
      m_s1x = int'(pix_x);
      m_s1y = int'(pix_y);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("score_sat",  32'(score_a),  bcd(m_score[0]));
      chk("hi_sat",     32'(hi_a),     bcd(m_hi[0]));
      chk("new_hi_sat", 32'(new_hi_a), 32'(m_new[0]));
      chk("pixel_sat",  32'(pixel_a),  32'(m_pixel[0]));
      chk("score_wrap", 32'(score_b),  bcd(m_score[1]));
      chk("hi_wrap",    32'(hi_b),     bcd(m_hi[1]));
      chk("new_hi_wrap",32'(new_hi_b), 32'(m_new[1]));
      chk("pixel_wrap", 32'(pixel_b),  32'(m_pixel[1]));
    end
  end

  // ---------------- directed stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(int n);
    inc = 1'b1;
    repeat (n) tick();
    inc = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic probe(string name, int x, int y, bit exp);
    pix_x = 10'(x);
    pix_y = 10'(y);
    tick();
    tick();
    chk(name, 32'(pixel_a), 32'(exp));
  endtask

  initial begin
    tick();
    reset = 1'b0;
    check_en = 1'b1;
    chk("rst_score", 32'(score_a), 32'h0);
    chk("rst_hi", 32'(hi_a), 32'h0);
    chk("rst_new_hi", 32'(new_hi_a), 32'h0);
    chk("rst_pixel", 32'(pixel_a), 32'h0);

    // 123 increments, capture, sweep the top row.
    pulse_inc(123);
    chk("score_123", 32'(score_a), 32'h0123);
    pulse_frame();
    pix_y = 10'(Y0);
    for (int x = X0 - 8; x < X0 + 6 * DIGITS * CELL + 8; x++) begin
      pix_x = 10'(x);
      tick();
    end
    probe("lz_slot0", X0, Y0, 1'b0);
    probe("one_r0c1", X0 + 56, Y0, 1'b1);
    probe("one_r0c0", X0 + 48, Y0, 1'b0);
    probe("two_r0c0", X0 + 96, Y0, 1'b1);
    probe("gap_col4", X0 + 32, Y0 + 8, 1'b0);

    // High-score capture and non-record game over.
    clear = 1'b1; tick(); clear = 1'b0;
    pulse_inc(50);
    game_over = 1'b1; tick(); game_over = 1'b0;
    chk("hi_50", 32'(hi_a), 32'h0050);
    chk("new_hi_set", 32'(new_hi_a), 32'h1);
    clear = 1'b1; tick(); clear = 1'b0;
    pulse_inc(30);
    game_over = 1'b1; tick(); game_over = 1'b0;
    chk("hi_kept", 32'(hi_a), 32'h0050);
    chk("new_hi_clr", 32'(new_hi_a), 32'h0);

    // clear beats inc.
    clear = 1'b1; tick(); clear = 1'b0;
    pulse_inc(7);
    clear = 1'b1; inc = 1'b1; tick(); clear = 1'b0; inc = 1'b0;
    chk("clear_beats_inc", 32'(score_a), 32'h0);

    // game_over with inc uses the pre-increment score.
    do_reset();
    pulse_inc(50);
    game_over = 1'b1; tick(); game_over = 1'b0;
    pulse_inc(10);
    game_over = 1'b1; inc = 1'b1; tick(); game_over = 1'b0; inc = 1'b0;
    chk("hi_60", 32'(hi_a), 32'h0060);
    chk("score_61", 32'(score_a), 32'h0061);

    // Blink over 32 frames: frame counter starts at 0 after reset.
    show_hi = 1'b0;
    for (int k = 0; k < 32; k++) begin
      pulse_frame();
      probe($sformatf("blink_f%0d", k), X0 + 152, Y0, k < 16);
    end

    // inc between frames leaves the picture alone.
    pulse_frame();
    probe("disp_61", X0 + 144, Y0 + 8, 1'b1);
    pulse_inc(1);
    probe("disp_hold", X0 + 144, Y0 + 8, 1'b1);
    pulse_frame();
    probe("disp_62", X0 + 144, Y0 + 8, 1'b0);
    probe("disp_62_on", X0 + 168, Y0 + 8, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("reset_pixel", 32'(pixel_a), 32'h0);

    // Saturation versus wrap at all-9s.
    do_reset();
    pulse_inc(9999);
    chk("sat_9999", 32'(score_a), 32'h9999);
    chk("wrap_9999", 32'(score_b), 32'h9999);
    pulse_inc(1);
    chk("sat_hold", 32'(score_a), 32'h9999);
    chk("wrap_zero", 32'(score_b), 32'h0000);

    // Randomised traffic, model-checked every cycle.
    for (int c = 0; c < 4000; c++) begin
      inc       = ($urandom_range(0, 1) == 1);
      clear     = ($urandom_range(0, 63) == 0);
      game_over = ($urandom_range(0, 31) == 0);
      frame     = ($urandom_range(0, 39) == 0);
      if (frame) show_hi = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 7) == 0) begin
        pix_x = 10'($urandom_range(0, 1023));
        pix_y = 10'($urandom_range(0, 1023));
      end else begin
        pix_x = 10'(X0 - 16 + int'($urandom_range(0, 6 * DIGITS * CELL + 32)));
        pix_y = 10'(Y0 - 4 + int'($urandom_range(0, 6 * CELL + 8)));
      end
      tick();
    end
    inc = 1'b0; clear = 1'b0; game_over = 1'b0; frame = 1'b0; reset = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
